// File: rtl/dso_parallel_decimator_if.sv
// Purpose : sample-bus, config and status bundle for dso_parallel_decimator.
// Latency : n/a (signal bundle only).
// Backpr. : none; the bus has no ready and the output rate never exceeds the input rate.
// Signals : cfg_load/dec_ratio/dec_mode/data_format (config strobe + values),
//           in_valid/data_in (input words), out_valid/data_out (packed results),
//           busy (group or partial output word pending).
// Modports: master = sample source/sink (testbench side), slave = decimator.
interface dso_parallel_decimator_if #(
  parameter int LANES    = 8,
  parameter int SAMPLE_W = 16,
  parameter int RATIO_W  = 16
);
  logic                      cfg_load;
  logic [RATIO_W-1:0]        dec_ratio;
  logic                      dec_mode;
  logic [1:0]                data_format;
  logic                      in_valid;
  logic [LANES*SAMPLE_W-1:0] data_in;
  logic                      out_valid;
  logic [LANES*SAMPLE_W-1:0] data_out;
  logic                      busy;

  modport master (
    output cfg_load, dec_ratio, dec_mode, data_format, in_valid, data_in,
    input  out_valid, data_out, busy
  );

  modport slave (
    input  cfg_load, dec_ratio, dec_mode, data_format, in_valid, data_in,
    output out_valid, data_out, busy
  );
endinterface

// File: rtl/dso_parallel_decimator.sv
// Purpose : run-time ratio decimator for LANES-parallel samples; point-sample or
//           min/max peak-detect per group, results repacked into full LANES words.
// Latency : 1 cycle in bypass (ratio 0); 3 cycles from the group-closing word otherwise.
// Backpr. : none; in_valid low simply holds state, output rate <= input rate.
// Ports   : clkin (rising edge), reset (sync, active high), bus (slave modport of
//           dso_parallel_decimator_if carrying config, input words, output words, busy).
// Option  : define PEAK_MODE_EN to compile in peak mode and the format-aware min/max
//           datapath; without it dec_mode/data_format are ignored (sample mode only).
module dso_parallel_decimator #(
  parameter int LANES    = 8,
  parameter int SAMPLE_W = 16,
  parameter int RATIO_W  = 16
) (
  input logic                    clkin,
  input logic                    reset,
  dso_parallel_decimator_if.slave bus
);

  localparam int KW = $clog2(LANES) + 1;
  localparam int DW = LANES * SAMPLE_W;
  typedef logic [SAMPLE_W-1:0] smp_t;

  logic [RATIO_W-1:0] ratio_q;
  logic [RATIO_W-1:0] cnt_q, cnt_d;
  logic [KW-1:0]      k_q, k_d;
  logic [DW-1:0]      pack_q, pack_d;
  logic [DW-1:0]      out_dat_q, out_dat_d;
  logic               out_vld_q, out_vld_d;
  logic               s1_vld_q, s1_first_q, s1_last_q;
  smp_t               s1_smp_q, acc_smp_q;
  logic               s2_vld_q;
  logic               peak, bypass, accept, first_w, last_w;
  smp_t               res_lo, res_hi;

`ifdef PEAK_MODE_EN
  logic mode_q, sgn_q;
  logic fmt_unused;
  smp_t s1_min_q, s1_max_q, acc_min_q, acc_max_q;
  smp_t lane_v, lane_min, lane_max, mrg_min, mrg_max;

  assign peak       = mode_q;
  assign fmt_unused = bus.data_format[1];

  // Signed compare by flipping the sign bit and comparing unsigned.
  function automatic logic lt(input smp_t a, input smp_t b, input logic sgn);
    return {a[SAMPLE_W-1] ^ sgn, a[SAMPLE_W-2:0]} < {b[SAMPLE_W-1] ^ sgn, b[SAMPLE_W-2:0]};
  endfunction

  always_comb begin
    lane_v   = '0;
    lane_min = bus.data_in[SAMPLE_W-1:0];
    lane_max = bus.data_in[SAMPLE_W-1:0];
    for (int i = 1; i < LANES; i++) begin
      lane_v = bus.data_in[i*SAMPLE_W +: SAMPLE_W];
      if (lt(lane_v, lane_min, sgn_q)) lane_min = lane_v;
      if (lt(lane_max, lane_v, sgn_q)) lane_max = lane_v;
    end
  end

  // First word of a group reloads the accumulator instead of merging.
  assign mrg_min = (s1_first_q || lt(s1_min_q, acc_min_q, sgn_q)) ? s1_min_q : acc_min_q;
  assign mrg_max = (s1_first_q || lt(acc_max_q, s1_max_q, sgn_q)) ? s1_max_q : acc_max_q;
  assign res_lo  = peak ? acc_min_q : acc_smp_q;
  assign res_hi  = acc_max_q;
`else
  logic cfg_unused;
  assign peak       = 1'b0;
  assign cfg_unused = bus.dec_mode ^ (^bus.data_format);
  assign res_lo     = acc_smp_q;
  assign res_hi     = acc_smp_q;
`endif

  assign bypass  = (ratio_q == '0);
  assign accept  = bus.in_valid & ~bus.cfg_load;  // words in the cfg_load cycle are dropped
  assign first_w = (cnt_q == '0);
  assign last_w  = (cnt_q == ratio_q - RATIO_W'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (bus.cfg_load) cnt_d = '0;
    else if (accept && !bypass) cnt_d = last_w ? '0 : cnt_q + RATIO_W'(1);
  end

  // Packer: results land in slot k (and k+1 for the max in peak mode);
  // the completed word is taken from pack_d so the last slot is included.
  always_comb begin
    k_d       = k_q;
    pack_d    = pack_q;
    out_vld_d = 1'b0;
    out_dat_d = out_dat_q;
    if (bypass) begin
      if (accept) begin
        out_vld_d = 1'b1;
        out_dat_d = bus.data_in;
      end
    end else if (s2_vld_q && !bus.cfg_load) begin
      for (int i = 0; i < LANES; i++) begin
        if (i == int'(k_q)) pack_d[i*SAMPLE_W +: SAMPLE_W] = res_lo;
        if (peak && (i == int'(k_q) + 1)) pack_d[i*SAMPLE_W +: SAMPLE_W] = res_hi;
      end
      k_d = k_q + (peak ? KW'(2) : KW'(1));
      if (k_d == KW'(LANES)) begin
        out_vld_d = 1'b1;
        out_dat_d = pack_d;
        k_d       = '0;
      end
    end
    if (bus.cfg_load) k_d = '0;
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      ratio_q    <= RATIO_W'(1);
      cnt_q      <= '0;
      k_q        <= '0;
      pack_q     <= '0;
      out_vld_q  <= 1'b0;
      out_dat_q  <= '0;
      s1_vld_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_smp_q   <= '0;
      s2_vld_q   <= 1'b0;
      acc_smp_q  <= '0;
`ifdef PEAK_MODE_EN
      mode_q     <= 1'b0;
      sgn_q      <= 1'b0;
      s1_min_q   <= '0;
      s1_max_q   <= '0;
      acc_min_q  <= '0;
      acc_max_q  <= '0;
`endif
    end else begin
      if (bus.cfg_load) begin
        ratio_q <= bus.dec_ratio;
`ifdef PEAK_MODE_EN
        mode_q  <= bus.dec_mode;
        sgn_q   <= bus.data_format[0];
`endif
      end
      cnt_q     <= cnt_d;
      k_q       <= k_d;
      pack_q    <= pack_d;
      out_vld_q <= out_vld_d;
      out_dat_q <= out_dat_d;

      // Stage 1: per-word reduction.
      s1_vld_q <= accept & ~bypass;
      if (accept) begin
        s1_first_q <= first_w;
        s1_last_q  <= last_w;
        s1_smp_q   <= bus.data_in[SAMPLE_W-1:0];
`ifdef PEAK_MODE_EN
        s1_min_q   <= lane_min;
        s1_max_q   <= lane_max;
`endif
      end

      // Stage 2: group accumulator; s2_vld marks a finished group result.
      s2_vld_q <= s1_vld_q & s1_last_q & ~bus.cfg_load;
      if (s1_vld_q && !bus.cfg_load) begin
        if (s1_first_q) acc_smp_q <= s1_smp_q;
`ifdef PEAK_MODE_EN
        acc_min_q <= mrg_min;
        acc_max_q <= mrg_max;
`endif
      end
    end
  end

  assign bus.out_valid = out_vld_q;
  assign bus.data_out  = out_dat_q;
  assign bus.busy      = (cnt_q != '0) | (k_q != '0) | s1_vld_q | s2_vld_q;

endmodule

// File: tb/tb_dso_parallel_decimator.sv
// Purpose : directed self-checking bench for dso_parallel_decimator (LANES=8, 16-bit).
// Latency : outputs sampled 1 time unit after each rising edge.
// Backpr. : none; stimulus is a linear sequence of directed steps.
module tb_dso_parallel_decimator;
  localparam int LANES    = 8;
  localparam int SAMPLE_W = 16;
  localparam int RATIO_W  = 16;
  localparam int DW       = LANES * SAMPLE_W;

  logic clkin;
  logic reset;
  int   checks, errors;
  int   cyc, n_out, out_cyc, w_cyc;
  logic [DW-1:0] out_last;

  dso_parallel_decimator_if #(.LANES(LANES), .SAMPLE_W(SAMPLE_W), .RATIO_W(RATIO_W)) bus ();

  dso_parallel_decimator #(.LANES(LANES), .SAMPLE_W(SAMPLE_W), .RATIO_W(RATIO_W)) dut (
    .clkin (clkin),
    .reset (reset),
    .bus   (bus)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clkin);
    #1;
    cyc++;
    if (bus.out_valid) begin
      n_out++;
      out_last = bus.data_out;
      out_cyc  = cyc;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [DW-1:0] d);
    bus.in_valid = 1'b1;
    bus.data_in  = d;
    tick();
    bus.in_valid = 1'b0;
    w_cyc = cyc;
  endtask

  task automatic cfg(input logic [RATIO_W-1:0] r, input logic m, input logic [1:0] f);
    bus.cfg_load    = 1'b1;
    bus.dec_ratio   = r;
    bus.dec_mode    = m;
    bus.data_format = f;
    tick();
    bus.cfg_load = 1'b0;
    n_out = 0;
  endtask

  function automatic logic [DW-1:0] fill(input logic [15:0] base, input logic [15:0] step);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) r[i*SAMPLE_W +: SAMPLE_W] = base + step * 16'(i);
    return r;
  endfunction

  function automatic logic [DW-1:0] pack8(input logic [15:0] a0, a1, a2, a3, a4, a5, a6, a7);
    return {a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  initial begin
    logic [DW-1:0] d;
    checks = 0; errors = 0; cyc = 0; n_out = 0; out_cyc = 0; w_cyc = 0; out_last = '0;
    reset = 1'b1;
    bus.cfg_load = 1'b0; bus.dec_ratio = '0; bus.dec_mode = 1'b0; bus.data_format = 2'b00;
    bus.in_valid = 1'b0; bus.data_in = '0;

    // Reset state.
    idle(2);
    chk_i("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_data_out", bus.data_out, '0);
    chk_i("rst_busy", int'(bus.busy), 0);
    reset = 1'b0;
    idle(1);

    // Default config: ratio 1, sample mode -> lane 0 of each of 8 words.
    n_out = 0;
    for (int w = 0; w < 8; w++) send(fill(16'(16'h40 + w), 16'h100));
    idle(4);
    chk_i("dflt_nout", n_out, 1);
    chk_i("dflt_lat", out_cyc, w_cyc + 2);
    chk("dflt_dat", out_last, fill(16'h40, 16'h1));

    // Bypass: each word reappears one cycle later.
    cfg(16'd0, 1'b0, 2'b00);
    chk_i("byp_idle", int'(bus.out_valid), 0);
    for (int w = 1; w <= 8; w++) begin
      d = fill(16'(w << 8), 16'h1);
      send(d);
      chk_i("byp_vld", int'(bus.out_valid), 1);
      chk("byp_dat", bus.data_out, d);
    end
    idle(1);
    chk_i("byp_end", int'(bus.out_valid), 0);
    chk_i("byp_busy", int'(bus.busy), 0);

    // Sample mode, ratio 4, 32 words: one output of lanes 0,4,..,28.
    cfg(16'd4, 1'b0, 2'b00);
    for (int w = 0; w < 32; w++) send(fill(16'(w), 16'h111));
    chk_i("r4_nout_pre", n_out, 0);
    idle(1);
    chk_i("r4_vld_p1", int'(bus.out_valid), 0);
    chk_i("r4_busy_p1", int'(bus.busy), 1);
    idle(1);
    chk_i("r4_vld_p2", int'(bus.out_valid), 1);
    chk("r4_dat", bus.data_out, fill(16'h0, 16'h4));
    chk_i("r4_busy_done", int'(bus.busy), 0);
    idle(1);
    chk_i("r4_strobe", int'(bus.out_valid), 0);

    // cfg_load after 3 words of a ratio-4 group; the word in the load cycle is dropped.
    cfg(16'd4, 1'b0, 2'b00);
    for (int w = 0; w < 3; w++) send(fill(16'(16'hF000 + w), 16'h7));
    bus.in_valid = 1'b1;
    bus.data_in  = fill(16'hEEEE, 16'h0);
    cfg(16'd4, 1'b0, 2'b00);
    bus.in_valid = 1'b0;
    chk_i("flush_busy", int'(bus.busy), 0);
    for (int w = 0; w < 32; w++) send(fill(16'(16'h200 + w), 16'h10));
    idle(4);
    chk_i("flush_nout", n_out, 1);
    chk("flush_dat", out_last, fill(16'h200, 16'h4));

    // in_valid toggling at ratio 2: same data as a continuous stream.
    cfg(16'd2, 1'b0, 2'b00);
    for (int w = 0; w < 16; w++) begin
      send(fill(16'(100 + w), 16'h333));
      if (w < 15) idle(1);
    end
    idle(5);
    chk_i("tog_nout", n_out, 1);
    chk_i("tog_lat", out_cyc, w_cyc + 2);
    chk("tog_dat", out_last, fill(16'd100, 16'd2));
    chk_i("tog_busy", int'(bus.busy), 0);

`ifdef PEAK_MODE_EN
    // Peak, signed, ratio 2: four groups -> four (min,max) pairs.
    cfg(16'd2, 1'b1, 2'b01);
    send(fill(16'h8000, 16'h0));  send(fill(16'h7FFF, 16'h0));
    send(fill(16'h0000, 16'h1));  send(fill(16'h0000, 16'hFFFF));
    send(fill(16'h1000, 16'h1));  send(fill(16'h1100, 16'h1));
    send(fill(16'h0005, 16'h0));  send(fill(16'h0005, 16'h0));
    idle(4);
    chk_i("pk_s_nout", n_out, 1);
    chk_i("pk_s_lat", out_cyc, w_cyc + 2);
    chk("pk_s_dat", out_last,
        pack8(16'h8000, 16'h7FFF, 16'hFFF9, 16'h0007, 16'h1000, 16'h1107, 16'h0005, 16'h0005));

    // Same data unsigned (reserved format bit set, must be ignored).
    cfg(16'd2, 1'b1, 2'b10);
    send(fill(16'h8000, 16'h0));  send(fill(16'h7FFF, 16'h0));
    send(fill(16'h0000, 16'h1));  send(fill(16'h0000, 16'hFFFF));
    send(fill(16'h1000, 16'h1));  send(fill(16'h1100, 16'h1));
    send(fill(16'h0005, 16'h0));  send(fill(16'h0005, 16'h0));
    idle(4);
    chk_i("pk_u_nout", n_out, 1);
    chk("pk_u_dat", out_last,
        pack8(16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF, 16'h1000, 16'h1107, 16'h0005, 16'h0005));

    // Peak, ratio 1: four words -> one word of four pairs, lanes shuffled.
    cfg(16'd1, 1'b1, 2'b00);
    for (int w = 0; w < 4; w++) begin
      d = '0;
      for (int i = 0; i < LANES; i++) d[i*SAMPLE_W +: SAMPLE_W] = 16'(w * 16 + (i * 3) % 8);
      send(d);
    end
    idle(4);
    chk_i("pk_r1_nout", n_out, 1);
    chk_i("pk_r1_lat", out_cyc, w_cyc + 2);
    chk("pk_r1_dat", out_last,
        pack8(16'h00, 16'h07, 16'h10, 16'h17, 16'h20, 16'h27, 16'h30, 16'h37));
`else
    // Without peak support dec_mode is ignored: ratio 1 behaves as sample mode.
    cfg(16'd1, 1'b1, 2'b01);
    for (int w = 0; w < 8; w++) send(fill(16'(16'h30 + w), 16'h1111));
    idle(4);
    chk_i("nopk_nout", n_out, 1);
    chk_i("nopk_lat", out_cyc, w_cyc + 2);
    chk("nopk_dat", out_last, fill(16'h30, 16'h1));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dso_parallel_decimator.md
# dso_parallel_decimator

Parametrised multi-rate decimator for the DSO acquisition path. It takes LANES parallel ADC samples per clock, reduces every group of `dec_ratio` input words to one result (point-sample or min/max peak-detect), and repacks the results into full LANES-wide output words. It sits after the interpolation/decimation chain, in the same clock domain as the parallel sample bus. It generalises the fixed hardware decimation stage with a run-time ratio, selectable mode, sign-aware compare and configurable lane count.

## Interface
- LANES, 8, samples per bus word; must be even, ≥2
- SAMPLE_W, 16, bits per sample
- RATIO_W, 16, width of `dec_ratio`

- clkin  in  1  sample-bus clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- cfg_load  in  1  one-cycle pulse: latch `dec_ratio`, `dec_mode`, `data_format`, flush pipeline
- dec_ratio  in  RATIO_W  input words per group; 0 = bypass
- dec_mode  in  1  0 = sample, 1 = peak (min/max)
- data_format  in  2  bit0: 1 = signed two's complement, 0 = unsigned; bit1 reserved, ignored
- in_valid  in  1  `data_in` word valid
- data_in  in  LANES*SAMPLE_W  lane i at bits [i*SAMPLE_W +: SAMPLE_W], lane 0 oldest
- out_valid  out  1  one-cycle strobe, `data_out` holds a full word
- data_out  out  LANES*SAMPLE_W  packed results, same lane order
- busy  out  1  high while a group or partial output word is pending

## Operation
- Config registers (ratio, mode, format) reset to ratio=1, mode=sample, unsigned; updated only on `cfg_load`. `cfg_load` also clears the group counter, packer slot index, and all pipeline valids, discarding partial data. Inputs arriving during the `cfg_load` cycle are dropped.
- Bypass (ratio=0): `data_out` <= `data_in`, `out_valid` <= `in_valid`, with one register stage. Mode is ignored.
- Group counter counts valid words 0..ratio-1 and wraps to 0 after ratio-1. The word with counter=ratio-1 is the last word of the group.
- Stage 1 registers, per valid word:
  - lane-0 sample
  - min and max across all lanes (compare signed or unsigned per the format bit)
  - first/last-of-group flags
- Stage 2 accumulator:
  - sample mode: result = lane-0 sample of the group's first word.
  - peak mode: min/max are loaded on the first word and merged on later words. Result = (min, max) of all ratio*LANES samples.
- Packer, on each stage-2 group result:
  - sample mode: writes 1 slot at index k, then k += 1.
  - peak mode: writes min to slot k and max to slot k+1, then k += 2.
  - When k reaches LANES, `data_out` is updated, `out_valid` pulses and k returns to 0.
- `in_valid` low stalls nothing. The group counter simply holds. There is no backpressure; output rate never exceeds input rate.
- `busy` = (group counter ≠ 0) | (k ≠ 0) | any stage valid.

## Timing
- Reset values:
  - `out_valid`=0, `data_out`=0, `busy`=0
  - counter=0, k=0, all stage valids 0
  - config at default values
- Bypass latency: 1 cycle from `in_valid` to `out_valid`.
- Decimate latency: `out_valid` rises exactly 3 cycles after the `in_valid` word that closes the group completing the output word:
  - stage 1 at +1
  - stage 2 at +2
  - packer output at +3
- Back-to-back groups at ratio=1 are sustained at full rate. The packer accepts one result per cycle.
- Reset or `cfg_load` during an in-flight group: no `out_valid` is issued for any data received before it. The first output after it contains only post-load data.
- `out_valid` is never high for two consecutive cycles unless ratio=0, or ratio=1 with LANES=2 in peak mode.

## Configuration
- `PEAK_MODE_EN` defined: peak mode, min/max datapath and format-aware compare are compiled in.
- Not defined:
  - `dec_mode` is ignored and treated as sample mode.
  - Stage 1 keeps only the lane-0 sample; min/max logic is absent.
  - Packer always advances k by 1.
  - Latency is unchanged (3 cycles).

## Test plan
- Reset, then `cfg_load` with ratio=0, stream words 0x0001…0x0008 per lane → each word reappears on `data_out` 1 cycle later with `out_valid` 1.
- Sample mode, ratio=4, LANES=8, lane-0 values 0,1,2,… per word for 32 words → one `out_valid`, lanes = 0,4,8,…,28, 3 cycles after word 31.
- Peak mode, signed, ratio=2, group containing 0x8000 and 0x7FFF → slot pair min=0x8000, max=0x7FFF. With unsigned format the same data gives min=0x7FFF, max=0x8000.
- Peak mode, ratio=1, LANES=8: 4 words produce exactly one output word of 4 (min,max) pairs, in group order.
- `cfg_load` pulsed after 3 words of a ratio=4 group, then 32 fresh words → no output from the partial group; the first output contains only post-load samples.
- `in_valid` toggling 1/0 every cycle at ratio=2, sample mode → outputs are identical to the continuous-stream case, only delayed by the gaps. `busy` falls after the final output.
